// File: rtl/multi_channel_clk_divider.sv
// NCH independent programmable dividers producing a 50%-duty clock or a one-cycle strobe.
// New divisor/mode settings are staged in a shadow and applied only at a period boundary.

module mcd_channel #(
    parameter int unsigned CW          = 26,
    parameter int unsigned DEFAULT_DIV = 59999999
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          wr_sel,
    input  logic [CW-1:0] wr_div,
    input  logic          wr_mode,
    output logic          clk_out,
    output logic          tick,
    output logic          pend
);
    logic [CW-1:0] count;
    logic [CW-1:0] div_act;
    logic [CW-1:0] div_sh;
    logic          mode_act;
    logic          mode_sh;
    logic          terminal;
    logic          apply;

    assign terminal = (count == div_act);
    // Toggle mode applies only on the falling edge so a full period always completes.
    assign apply    = pend && (!en || (terminal && (mode_act || clk_out)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            pend     <= 1'b0;
            div_act  <= CW'(DEFAULT_DIV);
            div_sh   <= CW'(DEFAULT_DIV);
            mode_act <= 1'b0;
            mode_sh  <= 1'b0;
        end else begin
            if (wr_sel) begin
                div_sh  <= wr_div;
                mode_sh <= wr_mode;
            end

            if (!en) begin
                count   <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (terminal) begin
                count   <= '0;
                tick    <= 1'b1;
                clk_out <= mode_act ? 1'b1 : ~clk_out;
            end else begin
                count <= count + CW'(1);
                tick  <= 1'b0;
                if (mode_act)
                    clk_out <= 1'b0;
            end

            // Apply overrides the normal update; the old shadow is used even if a write lands now.
            if (apply) begin
                div_act  <= div_sh;
                mode_act <= mode_sh;
                count    <= '0;
                clk_out  <= 1'b0;
            end

            if (wr_sel)
                pend <= 1'b1;
            else if (apply)
                pend <= 1'b0;
        end
    end
endmodule

module multi_channel_clk_divider #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned CW          = 26,
    parameter int unsigned DEFAULT_DIV = 59999999,
    localparam int unsigned CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] ch_en,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_div,
    input  logic           wr_mode,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] pend
);
    logic [NCH-1:0] wr_sel;

    // Channel indices >= NCH never match any instance, so such writes are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr_sel[i] = wr_en && (wr_ch == CHW'(i));

        mcd_channel #(
            .CW          (CW),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (ch_en[i]),
            .wr_sel  (wr_sel[i]),
            .wr_div  (wr_div),
            .wr_mode (wr_mode),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (pend[i])
        );
    end
endmodule

// File: tb/tb_multi_channel_clk_divider.sv
// Directed bench for multi_channel_clk_divider: expected waveforms are hand-derived bit masks
// indexed by the number of clock edges since the scenario started.

module tb_multi_channel_clk_divider;
    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int DEF = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] ch_en;
    logic           wr_en;
    logic [1:0]     wr_ch;
    logic [CW-1:0]  wr_div;
    logic           wr_mode;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pend;

    int total = 0;
    int bad   = 0;

    multi_channel_clk_divider #(.NCH(NCH), .CW(CW), .DEFAULT_DIV(DEF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ch_en   (ch_en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_mode (wr_mode),
        .clk_out (clk_out),
        .tick    (tick),
        .pend    (pend)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        ch_en   = '0;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_div  = '0;
        wr_mode = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_wr(input int ch, input int div, input logic mode);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_div  = CW'(div);
        wr_mode = mode;
    endtask

    task automatic test_reset();
        ch_en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_mode = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({clk_out, tick, pend} !== '0) begin
            bad++;
            $display("FAIL reset outputs got=%b exp=0", {clk_out, tick, pend});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_default_toggle();
        logic [31:0] exp_clk = 32'h000F_83E0;
        logic [31:0] exp_tck = 32'h0010_8420;
        do_reset();
        ch_en = 3'b001;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            total++;
            if (clk_out[0] !== exp_clk[e] || tick[0] !== exp_tck[e]) begin
                bad++;
                $display("FAIL default_toggle e=%0d clk/tick got=%b%b exp=%b%b",
                         e, clk_out[0], tick[0], exp_clk[e], exp_tck[e]);
            end
        end
    endtask

    task automatic test_write_toggle();
        logic [31:0] exp_clk = 32'h0003_33E0;
        logic [31:0] exp_tck = 32'h0001_5420;
        logic [31:0] exp_pnd = 32'h0000_0300;
        do_reset();
        ch_en = 3'b001;
        for (int e = 1; e <= 17; e++) begin
            @(negedge clk);
            total++;
            if (clk_out[0] !== exp_clk[e] || tick[0] !== exp_tck[e] || pend[0] !== exp_pnd[e]) begin
                bad++;
                $display("FAIL write_toggle e=%0d clk/tick/pend got=%b%b%b exp=%b%b%b",
                         e, clk_out[0], tick[0], pend[0], exp_clk[e], exp_tck[e], exp_pnd[e]);
            end
            if (e == 7) drive_wr(0, 1, 1'b0);
            else        wr_en = 1'b0;
        end
    endtask

    task automatic test_pulse_mode();
        logic [31:0] exp_clk = 32'h0009_23E0;
        logic [31:0] exp_tck = 32'h0009_2420;
        logic [31:0] exp_pnd = 32'h0000_03F8;
        do_reset();
        ch_en = 3'b010;
        for (int e = 1; e <= 19; e++) begin
            @(negedge clk);
            total++;
            if (clk_out[1] !== exp_clk[e] || tick[1] !== exp_tck[e] || pend[1] !== exp_pnd[e]) begin
                bad++;
                $display("FAIL pulse_mode e=%0d clk/tick/pend got=%b%b%b exp=%b%b%b",
                         e, clk_out[1], tick[1], pend[1], exp_clk[e], exp_tck[e], exp_pnd[e]);
            end
            if (e == 2) drive_wr(1, 2, 1'b1);
            else        wr_en = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_clk = 32'h0333_C3E0;
        logic [31:0] exp_pnd = 32'h0003_FFF8;
        do_reset();
        ch_en = 3'b001;
        for (int e = 1; e <= 25; e++) begin
            @(negedge clk);
            total++;
            if (clk_out[0] !== exp_clk[e] || pend[0] !== exp_pnd[e]) begin
                bad++;
                $display("FAIL back_to_back e=%0d clk/pend got=%b%b exp=%b%b",
                         e, clk_out[0], pend[0], exp_clk[e], exp_pnd[e]);
            end
            case (e)
                2:       drive_wr(0, 7, 1'b0);
                3:       drive_wr(0, 3, 1'b0);
                9:       drive_wr(0, 1, 1'b0);
                default: wr_en = 1'b0;
            endcase
        end
    endtask

    task automatic test_enable_reset();
        logic [31:0] exp_clk = 32'h0000_7060;
        logic [31:0] exp_tck = 32'h0000_9020;
        logic [31:0] exp_pnd = 32'h0000_0080;
        logic [31:0] exp_rst = 32'h0000_0060;
        do_reset();
        ch_en = 3'b001;
        for (int e = 1; e <= 15; e++) begin
            @(negedge clk);
            total++;
            if (clk_out[0] !== exp_clk[e] || tick[0] !== exp_tck[e] || pend[0] !== exp_pnd[e]) begin
                bad++;
                $display("FAIL enable e=%0d clk/tick/pend got=%b%b%b exp=%b%b%b",
                         e, clk_out[0], tick[0], pend[0], exp_clk[e], exp_tck[e], exp_pnd[e]);
            end
            wr_en = 1'b0;
            if (e == 6) begin
                ch_en = 3'b000;
                drive_wr(0, 2, 1'b0);
            end
            if (e == 9) ch_en = 3'b001;
        end

        // Asynchronous reset in the middle of a high phase.
        do_reset();
        ch_en = 3'b001;
        repeat (6) @(negedge clk);
        total++;
        if (clk_out[0] !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_high got=%b exp=1", clk_out[0]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({clk_out, tick, pend} !== '0) begin
            bad++;
            $display("FAIL async_reset got=%b exp=0", {clk_out, tick, pend});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            total++;
            if (clk_out[0] !== exp_rst[e]) begin
                bad++;
                $display("FAIL restart e=%0d got=%b exp=%b", e, clk_out[0], exp_rst[e]);
            end
        end
    endtask

    task automatic test_concurrent();
        logic [2:0]  exp_pnd [1:4] = '{3'b001, 3'b010, 3'b100, 3'b000};
        logic [31:0] exp_c0 = 32'h0000_0AAA;
        logic [31:0] exp_c1 = 32'h0000_0CCC;
        logic [31:0] exp_c2 = 32'h0000_0E38;
        logic [31:0] exp_t0 = 32'h0000_1FFE;
        logic [31:0] exp_t1 = 32'h0000_1554;
        logic [31:0] exp_t2 = 32'h0000_1248;
        logic [2:0]  ec, et;
        do_reset();
        drive_wr(0, 0, 1'b0);
        for (int s = 1; s <= 4; s++) begin
            @(negedge clk);
            total++;
            if (pend !== exp_pnd[s]) begin
                bad++;
                $display("FAIL setup_pend s=%0d got=%b exp=%b", s, pend, exp_pnd[s]);
            end
            case (s)
                1:       drive_wr(1, 1, 1'b0);
                2:       drive_wr(2, 2, 1'b0);
                3:       drive_wr(3, 5, 1'b1);
                default: wr_en = 1'b0;
            endcase
        end
        @(negedge clk);
        total++;
        if (pend !== 3'b000) begin
            bad++;
            $display("FAIL ignored_write pend got=%b exp=000", pend);
        end
        ch_en = 3'b111;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ec = {exp_c2[k], exp_c1[k], exp_c0[k]};
            et = {exp_t2[k], exp_t1[k], exp_t0[k]};
            total++;
            if (clk_out !== ec || tick !== et) begin
                bad++;
                $display("FAIL concurrent k=%0d clk=%b tick=%b exp clk=%b tick=%b",
                         k, clk_out, tick, ec, et);
            end
        end

        // N=0 in pulse mode holds both outputs high.
        ch_en = 3'b000;
        drive_wr(0, 0, 1'b1);
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        ch_en = 3'b001;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (clk_out[0] !== 1'b1 || tick[0] !== 1'b1) begin
                bad++;
                $display("FAIL pulse_n0 k=%0d clk/tick got=%b%b exp=11", k, clk_out[0], tick[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_toggle();
        test_write_toggle();
        test_pulse_mode();
        test_back_to_back();
        test_enable_reset();
        test_concurrent();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
